// File: rtl/rs_station.sv
// rs_station: reservation station that buffers renamed non-memory ops, wakes them from result buses and issues one per cycle
module rs_station #(
  parameter int RS_SIZE = 16,
  parameter int NICK_W  = 5,
  parameter int OP_W    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              iROB_clr,
  input  logic              iDP_en,
  input  logic              iDP_is_ls,
  input  logic [OP_W-1:0]   iDP_op,
  input  logic [31:0]       iDP_pc,
  input  logic [31:0]       iDP_imm,
  input  logic              iDP_pd,
  input  logic [NICK_W-1:0] iDP_rd_nick,
  input  logic [NICK_W-1:0] iDP_rs1_nick,
  input  logic [NICK_W-1:0] iDP_rs2_nick,
  input  logic [31:0]       iDP_rs1_dt,
  input  logic [31:0]       iDP_rs2_dt,
  input  logic              iALU_en,
  input  logic [NICK_W-1:0] iALU_nick,
  input  logic [31:0]       iALU_dt,
  input  logic              iLSB_en,
  input  logic [NICK_W-1:0] iLSB_nick,
  input  logic [31:0]       iLSB_dt,
  output logic              oRS_full,
  output logic              oRS_en,
  output logic [OP_W-1:0]   oRS_op,
  output logic [31:0]       oRS_pc,
  output logic [31:0]       oRS_imm,
  output logic              oRS_pd,
  output logic [NICK_W-1:0] oRS_rd_nick,
  output logic [31:0]       oRS_rs1_dt,
  output logic [31:0]       oRS_rs2_dt
);
  localparam int IW = $clog2(RS_SIZE);
  localparam int CW = $clog2(RS_SIZE + 1);
  typedef struct packed {
    logic              busy;
    logic [OP_W-1:0]   op;
    logic [31:0]       pc;
    logic [31:0]       imm;
    logic              pd;
    logic [NICK_W-1:0] rd;
    logic [NICK_W-1:0] q1;
    logic [NICK_W-1:0] q2;
    logic [31:0]       v1;
    logic [31:0]       v2;
  } ent_t;
  ent_t ent [RS_SIZE];
  ent_t dp;
  logic          fr_ok, is_ok;
  logic [IW-1:0] fr_idx, is_idx;
  logic [CW-1:0] nfree;
  // ALU beats LSB on a shared tag; a zero tag is already resolved and never matches
  function automatic logic [NICK_W+31:0] fwd(input logic [NICK_W-1:0] q, input logic [31:0] v);
    return (q != '0 && iALU_en && q == iALU_nick) ? {{NICK_W{1'b0}}, iALU_dt} :
           (q != '0 && iLSB_en && q == iLSB_nick) ? {{NICK_W{1'b0}}, iLSB_dt} : {q, v};
  endfunction
  // lowest free slot, lowest ready slot and free count, all from registered state
  always_comb begin
    fr_ok = 1'b0;
    fr_idx = '0;
    is_ok = 1'b0;
    is_idx = '0;
    nfree = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      fr_ok = fr_ok | !ent[i].busy;
      fr_idx = !ent[i].busy ? IW'(i) : fr_idx;
      is_ok = is_ok | (ent[i].busy && ent[i].q1 == '0 && ent[i].q2 == '0);
      is_idx = (ent[i].busy && ent[i].q1 == '0 && ent[i].q2 == '0) ? IW'(i) : is_idx;
      nfree = nfree + CW'(!ent[i].busy);
    end
  end
  assign oRS_full = nfree <= CW'(1);
  // incoming entry with operands forwarded from same-cycle broadcasts
  always_comb begin
    dp = '0;
    dp.busy = 1'b1;
    dp.op = iDP_op;
    dp.pc = iDP_pc;
    dp.imm = iDP_imm;
    dp.pd = iDP_pd;
    dp.rd = iDP_rd_nick;
    {dp.q1, dp.v1} = fwd(iDP_rs1_nick, iDP_rs1_dt);
    {dp.q2, dp.v2} = fwd(iDP_rs2_nick, iDP_rs2_dt);
  end
  // entry storage, wakeup, issue and dispatch write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
      oRS_en <= 1'b0;
      oRS_op <= '0;
      oRS_pc <= '0;
      oRS_imm <= '0;
      oRS_pd <= 1'b0;
      oRS_rd_nick <= '0;
      oRS_rs1_dt <= '0;
      oRS_rs2_dt <= '0;
    end else if (iROB_clr) begin
      for (int i = 0; i < RS_SIZE; i++) ent[i].busy <= 1'b0;
      oRS_en <= 1'b0;
    end else if (!rdy) begin
      oRS_en <= 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++)
        if (ent[i].busy) begin
          {ent[i].q1, ent[i].v1} <= fwd(ent[i].q1, ent[i].v1);
          {ent[i].q2, ent[i].v2} <= fwd(ent[i].q2, ent[i].v2);
        end
      oRS_en <= is_ok;
      if (is_ok) begin
        ent[is_idx].busy <= 1'b0;
        oRS_op <= ent[is_idx].op;
        oRS_pc <= ent[is_idx].pc;
        oRS_imm <= ent[is_idx].imm;
        oRS_pd <= ent[is_idx].pd;
        oRS_rd_nick <= ent[is_idx].rd;
        oRS_rs1_dt <= ent[is_idx].v1;
        oRS_rs2_dt <= ent[is_idx].v2;
      end
      if (iDP_en && !iDP_is_ls && fr_ok) ent[fr_idx] <= dp;
    end
  end
endmodule

// File: tb/tb_rs_station.sv
// tb_rs_station: directed and randomized checks of rs_station against a slot-array reference model
module tb_rs_station;
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, iROB_clr = 1'b0;
  logic iDP_en = 1'b0, iDP_is_ls = 1'b0, iDP_pd = 1'b0;
  logic [5:0] iDP_op = '0;
  logic [31:0] iDP_pc = '0, iDP_imm = '0, iDP_rs1_dt = '0, iDP_rs2_dt = '0;
  logic [4:0] iDP_rd_nick = '0, iDP_rs1_nick = '0, iDP_rs2_nick = '0;
  logic iALU_en = 1'b0, iLSB_en = 1'b0;
  logic [4:0] iALU_nick = '0, iLSB_nick = '0;
  logic [31:0] iALU_dt = '0, iLSB_dt = '0;
  logic oRS_full, oRS_en, oRS_pd;
  logic [5:0] oRS_op;
  logic [31:0] oRS_pc, oRS_imm, oRS_rs1_dt, oRS_rs2_dt;
  logic [4:0] oRS_rd_nick;
  int checks = 0, errors = 0;

  rs_station dut (
    .clk(clk), .rst(rst), .rdy(rdy), .iROB_clr(iROB_clr),
    .iDP_en(iDP_en), .iDP_is_ls(iDP_is_ls), .iDP_op(iDP_op), .iDP_pc(iDP_pc),
    .iDP_imm(iDP_imm), .iDP_pd(iDP_pd), .iDP_rd_nick(iDP_rd_nick),
    .iDP_rs1_nick(iDP_rs1_nick), .iDP_rs2_nick(iDP_rs2_nick),
    .iDP_rs1_dt(iDP_rs1_dt), .iDP_rs2_dt(iDP_rs2_dt),
    .iALU_en(iALU_en), .iALU_nick(iALU_nick), .iALU_dt(iALU_dt),
    .iLSB_en(iLSB_en), .iLSB_nick(iLSB_nick), .iLSB_dt(iLSB_dt),
    .oRS_full(oRS_full), .oRS_en(oRS_en), .oRS_op(oRS_op), .oRS_pc(oRS_pc),
    .oRS_imm(oRS_imm), .oRS_pd(oRS_pd), .oRS_rd_nick(oRS_rd_nick),
    .oRS_rs1_dt(oRS_rs1_dt), .oRS_rs2_dt(oRS_rs2_dt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] q; logic [31:0] v; } opnd_t;
  typedef struct {
    bit busy; logic [5:0] op; logic [31:0] pc, imm; bit pd; logic [4:0] rd; opnd_t a, b;
  } ment_t;
  ment_t m [16];
  bit m_en, m_pd;
  logic [5:0] m_op;
  logic [31:0] m_pc, m_imm, m_v1, m_v2;
  logic [4:0] m_rd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic opnd_t resolve(opnd_t o);
    opnd_t r = o;
    if (o.q != 0 && iALU_en && iALU_nick == o.q) r = '{q: 5'd0, v: iALU_dt};
    else if (o.q != 0 && iLSB_en && iLSB_nick == o.q) r = '{q: 5'd0, v: iLSB_dt};
    return r;
  endfunction

  function automatic int free_cnt();
    int n = 0;
    foreach (m[i]) n += m[i].busy ? 0 : 1;
    return n;
  endfunction

  task automatic model_step();
    int c = -1, f = -1;
    if (rst) begin
      foreach (m[i]) m[i].busy = 0;
      {m_en, m_pd, m_op, m_pc, m_imm, m_v1, m_v2, m_rd} = '0;
    end else if (iROB_clr) begin
      foreach (m[i]) m[i].busy = 0;
      m_en = 0;
    end else if (!rdy) begin
      m_en = 0;
    end else begin
      for (int i = 15; i >= 0; i--) begin
        if (m[i].busy && m[i].a.q == 0 && m[i].b.q == 0) c = i;
        if (!m[i].busy) f = i;
      end
      foreach (m[i]) if (m[i].busy) begin
        m[i].a = resolve(m[i].a);
        m[i].b = resolve(m[i].b);
      end
      m_en = c >= 0;
      if (c >= 0) begin
        m_op = m[c].op; m_pc = m[c].pc; m_imm = m[c].imm; m_pd = m[c].pd;
        m_rd = m[c].rd; m_v1 = m[c].a.v; m_v2 = m[c].b.v;
        m[c].busy = 0;
      end
      if (iDP_en && !iDP_is_ls) begin
        if (f < 0) begin
          errors++;
          $display("FAIL dp_overflow: dispatch with no free entry");
        end else begin
          m[f] = '{busy: 1, op: iDP_op, pc: iDP_pc, imm: iDP_imm, pd: iDP_pd, rd: iDP_rd_nick,
                   a: resolve('{q: iDP_rs1_nick, v: iDP_rs1_dt}),
                   b: resolve('{q: iDP_rs2_nick, v: iDP_rs2_dt})};
        end
      end
    end
  endtask

  task automatic compare();
    check("en", 64'(oRS_en), 64'(m_en));
    check("full", 64'(oRS_full), 64'(free_cnt() <= 1));
    check("op_pd_rd", {51'd0, oRS_op, oRS_pd, oRS_rd_nick}, {51'd0, m_op, m_pd, m_rd});
    check("pc_imm", {oRS_pc, oRS_imm}, {m_pc, m_imm});
    check("rs_dt", {oRS_rs1_dt, oRS_rs2_dt}, {m_v1, m_v2});
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare();
    iDP_en = 0; iDP_is_ls = 0; iALU_en = 0; iLSB_en = 0; iROB_clr = 0;
  endtask

  task automatic dispatch(input logic [5:0] op, input logic [31:0] imm, input logic [4:0] rd,
                          input logic [4:0] q1, input logic [31:0] v1,
                          input logic [4:0] q2, input logic [31:0] v2);
    iDP_en = 1; iDP_is_ls = 0; iDP_op = op; iDP_pc = 32'h1000 + {27'd0, rd} * 4;
    iDP_imm = imm; iDP_pd = rd[0]; iDP_rd_nick = rd;
    iDP_rs1_nick = q1; iDP_rs1_dt = v1; iDP_rs2_nick = q2; iDP_rs2_dt = v2;
  endtask

  initial begin
    foreach (m[i]) m[i] = '{busy: 0, op: 0, pc: 0, imm: 0, pd: 0, rd: 0, a: '{0, 0}, b: '{0, 0}};
    #1;
    step();
    step();
    check("rst_full", 64'(oRS_full), 64'd0);
    rst = 0;
    dispatch(6'h13, 32'd3, 5'd2, 5'd0, 32'd5, 5'd0, 32'd0);
    step();
    check("t1_wait", 64'(oRS_en), 64'd0);
    step();
    check("t1_en", 64'(oRS_en), 64'd1);
    check("t1_rs1", 64'(oRS_rs1_dt), 64'd5);
    check("t1_rd", 64'(oRS_rd_nick), 64'd2);
    step();
    dispatch(6'h33, 32'd0, 5'd3, 5'd4, 32'd0, 5'd0, 32'd7);
    step();
    step();
    check("t2_hold", 64'(oRS_en), 64'd0);
    iALU_en = 1; iALU_nick = 5'd4; iALU_dt = 32'h10;
    step();
    step();
    check("t2_en", 64'(oRS_en), 64'd1);
    check("t2_rs1", 64'(oRS_rs1_dt), 64'h10);
    dispatch(6'h33, 32'd0, 5'd5, 5'd0, 32'd1, 5'd7, 32'd0);
    iLSB_en = 1; iLSB_nick = 5'd7; iLSB_dt = 32'hAB;
    step();
    step();
    check("t3_en", 64'(oRS_en), 64'd1);
    check("t3_rs2", 64'(oRS_rs2_dt), 64'hAB);
    step();
    for (int i = 0; i < 15; i++) begin
      dispatch(6'h33, 32'(i), 5'(i + 1), (i == 3 || i == 9) ? 5'd30 : 5'(10 + i), 32'd0, 5'd0, 32'(i));
      step();
    end
    check("t4_full", 64'(oRS_full), 64'd1);
    iALU_en = 1; iALU_nick = 5'd30; iALU_dt = 32'h55;
    step();
    step();
    check("t4_first", 64'(oRS_rd_nick), 64'd4);
    step();
    check("t4_second", 64'(oRS_rd_nick), 64'd10);
    check("t4_full_drop", 64'(oRS_full), 64'd0);
    iROB_clr = 1;
    step();
    for (int i = 0; i < 4; i++) begin
      dispatch(6'h33, 32'd0, 5'(20 + i), 5'd25, 32'd0, 5'd0, 32'd0);
      step();
    end
    iROB_clr = 1;
    dispatch(6'h13, 32'd1, 5'd9, 5'd0, 32'd9, 5'd0, 32'd0);
    step();
    check("t5_en", 64'(oRS_en), 64'd0);
    check("t5_full", 64'(oRS_full), 64'd0);
    step();
    check("t5_drop", 64'(oRS_en), 64'd0);
    dispatch(6'h13, 32'd2, 5'd11, 5'd0, 32'd6, 5'd0, 32'd0);
    step();
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_stall", 64'(oRS_en), 64'd0);
    end
    rdy = 1;
    step();
    check("t6_issue", 64'(oRS_en), 64'd1);
    step();
    check("t6_once", 64'(oRS_en), 64'd0);
    for (int n = 0; n < 3000; n++) begin
      rdy = $urandom_range(0, 7) != 0;
      iROB_clr = $urandom_range(0, 79) == 0;
      if (free_cnt() > 1 && $urandom_range(0, 2) != 0) begin
        dispatch(6'($urandom), $urandom, 5'($urandom_range(1, 31)),
                 ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 7)), $urandom,
                 ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 7)), $urandom);
        iDP_is_ls = $urandom_range(0, 4) == 0;
      end
      iALU_en = $urandom_range(0, 1) == 1;
      iALU_nick = 5'($urandom_range(0, 7));
      iALU_dt = $urandom;
      iLSB_en = $urandom_range(0, 2) == 0;
      iLSB_nick = 5'($urandom_range(0, 7));
      iLSB_dt = $urandom;
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
